game_ms_timer: RTL and testbench



---
 rtl/game_ms_timer_pkg.sv | 20 ++
 rtl/game_ms_timer_if.sv | 22 ++
 rtl/game_ms_timer_lfsr16.sv | 28 ++
 rtl/game_ms_timer.sv | 131 +++++++++++++
 tb/tb_game_ms_timer.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/game_ms_timer_pkg.sv
// Shared types and constants for the whack-a-mole millisecond timer and its LFSR.
package game_pkg;

    localparam int          MS_WIDTH     = 11;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        T_CLEAR = 2'd0,
        T_RUN   = 2'd1,
        T_HOLD  = 2'd2,
        T_SAT   = 2'd3
    } timer_state_t;

    // Galois right-shift form of x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/game_ms_timer_if.sv
// Control and result signals between the game FSM (master) and the timer (slave).
interface game_ms_timer_if;
    import game_pkg::*;

    logic                reset;
    logic                up;
    logic                enable;
    logic [MS_WIDTH-1:0] timer_value;
    logic [MS_WIDTH-1:0] random_value;
    logic                ms_tick;

    modport master (
        output reset, up, enable,
        input  timer_value, random_value, ms_tick
    );

    modport slave (
        input  reset, up, enable,
        output timer_value, random_value, ms_tick
    );

endinterface

// File: rtl/game_ms_timer_lfsr16.sv
// Free-running 16-bit Galois LFSR; only rst_n reloads the seed.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    // A zero seed would lock the register at zero forever
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] state_r;

    // Seed load on reset, otherwise one shift per clock
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= SEED_EFF;
        end else begin
            state_r <= lfsr_next(state_r);
        end
    end

    assign state = state_r;

endmodule

// File: rtl/game_ms_timer.sv
// Millisecond up/down counter with prescaler, clear/hold/saturate FSM and LFSR random source.
// Define TIMER_WRAP_EN to wrap at the limits instead of saturating.
module game_ms_timer
    import game_pkg::*;
#(
    parameter int          CLKS_PER_MS = 50000,
    parameter int          MAX_MS      = 2047,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    game_ms_timer_if.slave   tif
);

    localparam int                  PW         = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0]       PRESC_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [PW-1:0]       PRESC_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]       PRESC_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [MS_WIDTH-1:0] MAX_V      = MS_WIDTH'(MAX_MS);
    localparam logic [MS_WIDTH-1:0] ZERO_V     = {MS_WIDTH{1'b0}};
    localparam logic [MS_WIDTH-1:0] ONE_V      = {{(MS_WIDTH-1){1'b0}}, 1'b1};

    timer_state_t        state_r, state_s;
    logic [PW-1:0]       presc_r, presc_s;
    logic [MS_WIDTH-1:0] count_r, count_s;
    logic                tick_r, tick_s;
    logic                limit_hit_s;
    logic [15:0]         lfsr_state_s;
    logic                lfsr_unused_s;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr_state_s)
    );

    // Prescaler: counts enabled cycles, holds a partial millisecond while disabled
    always_comb begin
        presc_s = presc_r;
        tick_s  = 1'b0;
        if (tif.reset) begin
            presc_s = PRESC_ZERO;
        end else if (tif.enable) begin
            if (presc_r == PRESC_LAST) begin
                presc_s = PRESC_ZERO;
                tick_s  = 1'b1;
            end else begin
                presc_s = presc_r + PRESC_ONE;
            end
        end else begin
            presc_s = presc_r;
        end
    end

    // Count update on tick; direction is whatever up reads in the tick cycle
    always_comb begin
        count_s = count_r;
        if (tif.reset) begin
            count_s = ZERO_V;
        end else if (tick_s) begin
`ifdef TIMER_WRAP_EN
            if (tif.up) begin
                count_s = (count_r >= MAX_V) ? ZERO_V : count_r + ONE_V;
            end else begin
                count_s = (count_r == ZERO_V) ? MAX_V : count_r - ONE_V;
            end
`else
            if (tif.up) begin
                count_s = (count_r >= MAX_V) ? MAX_V : count_r + ONE_V;
            end else begin
                count_s = (count_r == ZERO_V) ? ZERO_V : count_r - ONE_V;
            end
`endif
        end else begin
            count_s = count_r;
        end
    end

`ifdef TIMER_WRAP_EN
    assign limit_hit_s = 1'b0;
`else
    assign limit_hit_s = tif.up ? (count_s == MAX_V) : (count_s == ZERO_V);
`endif

    // Counter FSM next state; leaving T_SAT means the tick actually moved the count
    always_comb begin
        state_s = state_r;
        if (tif.reset) begin
            state_s = T_CLEAR;
        end else begin
            case (state_r)
                T_CLEAR: state_s = tif.enable ? T_RUN : T_CLEAR;
                T_RUN: begin
                    if (!tif.enable) begin
                        state_s = T_HOLD;
                    end else if (tick_s && limit_hit_s) begin
                        state_s = T_SAT;
                    end else begin
                        state_s = T_RUN;
                    end
                end
                T_HOLD:  state_s = tif.enable ? T_RUN : T_HOLD;
                T_SAT:   state_s = (tick_s && (count_s != count_r)) ? T_RUN : T_SAT;
                default: state_s = T_CLEAR;
            endcase
        end
    end

    // State, prescaler, count and tick registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= T_CLEAR;
            presc_r <= PRESC_ZERO;
            count_r <= ZERO_V;
            tick_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            presc_r <= presc_s;
            count_r <= count_s;
            tick_r  <= tick_s;
        end
    end

    assign tif.timer_value  = count_r;
    assign tif.ms_tick      = tick_r;
    assign tif.random_value = lfsr_state_s[MS_WIDTH-1:0];
    assign lfsr_unused_s    = ^lfsr_state_s[15:MS_WIDTH];

endmodule

// File: tb/tb_game_ms_timer.sv
// Directed table-driven bench for game_ms_timer (CLKS_PER_MS=4, MAX_MS=10) with an LFSR reference.
module tb_game_ms_timer;
    import game_pkg::*;

    localparam int CPM   = 4;
    localparam int MAXMS = 10;
`ifdef TIMER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        logic        rst_n;
        logic        reset;
        logic        enable;
        logic        up;
        int          cycles;
        logic [10:0] exp_val;
        logic        exp_tick;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          done  = 1'b0;
    logic [15:0] m_lfsr;
    bit          m_valid = 1'b0;
    vec_t        tbl[$];

    game_ms_timer_if tif();

    game_ms_timer #(
        .CLKS_PER_MS (CPM),
        .MAX_MS      (MAXMS),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tif   (tif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference LFSR written bit by bit: n = s>>1, xor 0xB400 when s[0] was set
    function automatic logic [15:0] model_step(input logic [15:0] s);
        return {s[0], s[15], s[14] ^ s[0], s[13] ^ s[0], s[12], s[11] ^ s[0], s[10:1]};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_lfsr  <= 16'hACE1;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_lfsr <= model_step(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (m_valid && !done) begin
            check("random_value", 32'(tif.random_value), 32'(m_lfsr[10:0]));
        end
    end

    task automatic add(input logic rn, input logic rs, input logic en, input logic u,
                       input int cy, input logic [10:0] ev, input logic et);
        vec_t v;
        v.rst_n = rn; v.reset = rs; v.enable = en; v.up = u;
        v.cycles = cy; v.exp_val = ev; v.exp_tick = et;
        tbl.push_back(v);
    endtask

    initial begin
        tif.reset  = 1'b0;
        tif.enable = 1'b0;
        tif.up     = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset timer_value", 32'(tif.timer_value), 32'd0);
        check("reset ms_tick", 32'(tif.ms_tick), 32'd0);
        check("reset random_value", 32'(tif.random_value), 32'h4E1);

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("lfsr first step", 32'(tif.random_value), 32'h270);
        check("idle timer_value", 32'(tif.timer_value), 32'd0);

        //  rst_n reset en up cycles value tick
        add(1'b1, 1'b0, 1'b1, 1'b1, 3,  11'd0,  1'b0);   // first tick not before cycle 4
        add(1'b1, 1'b0, 1'b1, 1'b1, 1,  11'd1,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1,  11'd1,  1'b0);   // tick is a single-cycle pulse
        add(1'b1, 1'b0, 1'b1, 1'b1, 3,  11'd2,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 12, 11'd5,  1'b1);   // 20 cycles -> 5
        add(1'b1, 1'b0, 1'b1, 1'b1, 20, 11'd10, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 4,  WRAP ? 11'd0 : 11'd10, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 4,  WRAP ? 11'd1 : 11'd10, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 2,  WRAP ? 11'd1 : 11'd10, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1,  11'd0,  1'b0);   // rst_n mid-count, prescaler at 2
        add(1'b1, 1'b0, 1'b1, 1'b1, 3,  11'd0,  1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1,  11'd1,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 8,  11'd3,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4,  11'd2,  1'b1);   // count down from 3
        add(1'b1, 1'b0, 1'b1, 1'b0, 4,  11'd1,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4,  11'd0,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4,  WRAP ? 11'd10 : 11'd0, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4,  WRAP ? 11'd9  : 11'd0, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 4,  WRAP ? 11'd10 : 11'd1, 1'b1);   // leave the low limit
        add(1'b0, 1'b0, 1'b0, 1'b1, 1,  11'd0,  1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 2,  11'd0,  1'b0);   // prescaler = 2
        add(1'b1, 1'b0, 1'b0, 1'b1, 7,  11'd0,  1'b0);   // held for 7 cycles
        add(1'b1, 1'b0, 1'b1, 1'b1, 1,  11'd0,  1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1,  11'd1,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 3,  11'd1,  1'b0);   // prescaler = 3
        add(1'b1, 1'b0, 1'b0, 1'b1, 1,  11'd1,  1'b0);   // enable dropped in tick cycle
        add(1'b1, 1'b0, 1'b0, 1'b1, 3,  11'd1,  1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1,  11'd2,  1'b1);   // tick on first re-enabled edge
        add(1'b1, 1'b0, 1'b1, 1'b1, 16, 11'd6,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 3,  11'd6,  1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1,  11'd0,  1'b0);   // reset beats enable in tick cycle
        add(1'b1, 1'b1, 1'b1, 1'b1, 5,  11'd0,  1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 3,  11'd0,  1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1,  11'd1,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 2,  11'd1,  1'b0);   // up toggled mid-millisecond
        add(1'b1, 1'b0, 1'b1, 1'b1, 1,  11'd1,  1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1,  11'd2,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 3,  11'd2,  1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1,  11'd1,  1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n      = tbl[i].rst_n;
            tif.reset  = tbl[i].reset;
            tif.enable = tbl[i].enable;
            tif.up     = tbl[i].up;
            repeat (tbl[i].cycles) @(posedge clk);
            #1;
            check($sformatf("row%0d timer_value", i), 32'(tif.timer_value), 32'(tbl[i].exp_val));
            check($sformatf("row%0d ms_tick", i), 32'(tif.ms_tick), 32'(tbl[i].exp_tick));
        end

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
